// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory port, redirect port and decode handshake.
interface fetch_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned OW = $clog2(DEPTH) + 1;

   logic [31:0]   imem_addr;
   logic [31:0]   imem_instr;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          if_valid;
   logic          if_ready;
   logic [31:0]   if_instr;
   logic [31:0]   if_pc;
   logic [OW-1:0] occupancy;

   // Fetch unit side
   modport master (
      output imem_addr,
      input  imem_instr,
      input  redirect_valid,
      input  redirect_pc,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc,
      output occupancy
   );

   // Memory / execute / decode side
   modport slave (
      input  imem_addr,
      output imem_instr,
      output redirect_valid,
      output redirect_pc,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc,
      input  occupancy
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch initiator: owns the PC, reads a combinational instruction
// memory and buffers {pc, instr} pairs in a circular queue toward decode.
// Optional zero-latency bypass when the queue is empty: define FETCH_BYPASS_EN.
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input logic            clk,
   input logic            rst_n,
   fetch_queue_if.master  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [31:0]   pc_q;

   logic          empty_c;
   logic          full_c;
   logic          valid_c;
   logic          qpop_c;
   logic          fetch_c;
   logic          push_c;
   logic [31:0]   target_c;
   entry_t        head_c;
   logic          unused_bits_c;

   assign unused_bits_c = ^bus.redirect_pc[1:0];

   // Queue status, decode-facing outputs and fetch/push/pop decisions
   always_comb begin
      empty_c  = (wr_ptr_q == rd_ptr_q);
      full_c   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head_c   = mem_q[rd_ptr_q[AW-1:0]];
      target_c = {bus.redirect_pc[31:2], 2'b00};
      valid_c       = ~empty_c;
      bus.if_instr  = 32'h0;
      bus.if_pc     = 32'h0;
      if (!empty_c) begin
         bus.if_instr = head_c.instr;
         bus.if_pc    = head_c.pc;
      end
`ifdef FETCH_BYPASS_EN
      if (empty_c && !bus.redirect_valid) begin
         valid_c      = 1'b1;
         bus.if_instr = bus.imem_instr;
         bus.if_pc    = pc_q;
      end
`endif
      bus.if_valid = valid_c;
      qpop_c       = ~empty_c & bus.if_ready;
      fetch_c      = ~bus.redirect_valid & (~full_c | qpop_c);
      push_c       = fetch_c;
`ifdef FETCH_BYPASS_EN
      // A word handed straight to decode is consumed, never queued
      if (empty_c && bus.if_ready) push_c = 1'b0;
`endif
   end

   assign bus.imem_addr = pc_q;
   assign bus.occupancy = wr_ptr_q - rd_ptr_q;

   // PC and queue pointers; redirect flushes and retargets ahead of everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (bus.redirect_valid) begin
         pc_q     <= target_c;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (fetch_c) pc_q     <= pc_q + 32'd4;
         if (push_c)  wr_ptr_q <= wr_ptr_q + PW'(1);
         if (qpop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Queue storage; contents are only observed through valid pointers
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= '{pc: pc_q, instr: bus.imem_instr};
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus randomized bench for fetch_queue with a queue-based reference model.
module tb_fetch_queue;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk;
   logic rst_n;
   logic rst2_n;

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   logic [31:0] mpc;

   fetch_queue_if #(.DEPTH(DEPTH)) b1 ();
   fetch_queue_if #(.DEPTH(DEPTH)) b2 ();

   fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b1));

   fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
      .clk(clk), .rst_n(rst2_n), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h0:   imem = 32'h00018880;
         32'h4:   imem = 32'h04221880;
         32'h8:   imem = 32'h102520C0;
         32'hC:   imem = 32'h08062880;
         default: imem = {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
      endcase
   endfunction

   always_comb b1.imem_instr = imem(b1.imem_addr);
   always_comb b2.imem_instr = imem(b2.imem_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every observable output of dut against the model
   task automatic check_all(input string tag);
      logic [31:0] epc;
      logic [31:0] eins;
      epc  = 32'h0;
      eins = 32'h0;
      if (q.size() != 0) begin
         epc  = q[0].pc;
         eins = q[0].instr;
      end
      check({tag, ".valid"}, 32'(b1.if_valid), 32'(q.size() != 0));
      check({tag, ".pc"},    b1.if_pc, epc);
      check({tag, ".instr"}, b1.if_instr, eins);
      check({tag, ".occ"},   32'(b1.occupancy), 32'(q.size()));
      check({tag, ".addr"},  b1.imem_addr, mpc);
   endtask

   // One clock of stimulus; the model applies the queue rules at the same edge
   task automatic step(input string tag, input logic rdy, input logic rv, input logic [31:0] rpc);
      int   n;
      bit   pop;
      ent_t e;
      b1.if_ready       = rdy;
      b1.redirect_valid = rv;
      b1.redirect_pc    = rpc;
      n   = q.size();
      pop = rdy && (n > 0);
      if (rv) begin
         q.delete();
         mpc = {rpc[31:2], 2'b00};
      end else begin
         if (pop) q.delete(0);
         if ((n < DEPTH) || pop) begin
            e.pc    = mpc;
            e.instr = imem(mpc);
            q.push_back(e);
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between edges, checked before any clock
   task automatic do_reset(input string tag);
      b1.if_ready       = 1'b0;
      b1.redirect_valid = 1'b0;
      b1.redirect_pc    = 32'h0;
      rst_n = 1'b0;
      q.delete();
      mpc = 32'h0;
      #1;
      check_all(tag);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b1;
      rst2_n = 1'b0;
      b2.if_ready       = 1'b1;
      b2.redirect_valid = 1'b0;
      b2.redirect_pc    = 32'h0;
      q.delete();
      mpc = 32'h0;
      @(posedge clk);
      #1;
      do_reset("reset");
      check("wrap.rst_addr", b2.imem_addr, 32'hFFFF_FFF8);
      check("wrap.rst_valid", 32'(b2.if_valid), 32'h0);
      rst2_n = 1'b1;

      // Reset and stream, with the wrapping instance streaming alongside
      step("stream0", 1'b1, 1'b0, 32'h0);
      check("stream0.pc", b1.if_pc, 32'h0);
      check("wrap0", b2.if_pc, 32'hFFFF_FFF8);
      step("stream1", 1'b1, 1'b0, 32'h0);
      check("wrap1", b2.if_pc, 32'hFFFF_FFFC);
      step("stream2", 1'b1, 1'b0, 32'h0);
      check("wrap2", b2.if_pc, 32'h0000_0000);
      check("wrap2.occ", 32'(b2.occupancy), 32'h1);
      step("stream3", 1'b1, 1'b0, 32'h0);
      check("stream3.pc", b1.if_pc, 32'hC);
      check("stream3.instr", b1.if_instr, 32'h08062880);

      // Backpressure and fill from a fresh reset
      do_reset("reset2");
      for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b0, 32'h0);
      check("fill.occ4", 32'(b1.occupancy), 32'h4);
      check("fill.addr16", b1.imem_addr, 32'h10);
      // First ready cycle while full: push and pop together
      step("fullpp", 1'b1, 1'b0, 32'h0);
      check("fullpp.occ", 32'(b1.occupancy), 32'h4);
      check("fullpp.pc", b1.if_pc, 32'h4);
      for (int i = 0; i < 5; i++) step("drain", 1'b1, 1'b0, 32'h0);

      // Redirect flush with three queued entries
      do_reset("reset3");
      for (int i = 0; i < 3; i++) step("pre_redir", 1'b0, 1'b0, 32'h0);
      check("pre_redir.occ", 32'(b1.occupancy), 32'h3);
      step("redir", 1'b1, 1'b1, 32'h0000_0043);
      check("redir.valid", 32'(b1.if_valid), 32'h0);
      step("redir_next", 1'b0, 1'b0, 32'h0);
      check("redir_next.pc", b1.if_pc, 32'h40);
      // Back-to-back redirects: the later target wins
      step("rr0", 1'b0, 1'b1, 32'h0000_1001);
      step("rr1", 1'b1, 1'b1, 32'h0000_2002);
      step("rr2", 1'b1, 1'b0, 32'h0);
      check("rr2.pc", b1.if_pc, 32'h2000);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        rdy;
         logic        rv;
         logic [31:0] rpc;
         rdy = ($urandom_range(0, 3) != 0);
         if (i % 100 > 60) rdy = ($urandom_range(0, 4) == 0);
         rv  = ($urandom_range(0, 11) == 0);
         rpc = $urandom;
         step("rand", rdy, rv, rpc);
      end

      // Asynchronous reset mid-stream with two entries held
      do_reset("reset4");
      for (int i = 0; i < 2; i++) step("pre_async", 1'b0, 1'b0, 32'h0);
      check("pre_async.occ", 32'(b1.occupancy), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async.valid", 32'(b1.if_valid), 32'h0);
      check("async.occ", 32'(b1.occupancy), 32'h0);
      check("async.addr", b1.imem_addr, 32'h0);
      #2;
      rst_n = 1'b1;
      q.delete();
      mpc = 32'h0;
      step("post_async", 1'b1, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch initiator for the pipeline front end. It owns the program counter, drives word addresses into the combinational-read instruction memory, and captures the returned instruction words into a small queue. The queue feeds the decode stage through a valid/ready handshake. It also accepts branch/jump redirects from execute and flushes wrong-path instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; low two bits must be 0.
- DEPTH, 4, queue entries; power of two, 2..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  32  fetch address, always equal to the PC register.
- imem_instr  in  32  instruction word at imem_addr, valid in the same cycle (combinational memory).
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- if_valid  out  1  head entry available to decode.
- if_ready  in  1  decode accepts the head entry this cycle.
- if_instr  out  32  head instruction word; 0 when if_valid=0.
- if_pc  out  32  address of the head instruction; 0 when if_valid=0.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

Clock is `clk`. Reset is `rst_n`: asynchronous and active-low.

## Operation
- Storage: a circular queue of {pc, instr} pairs with read/write pointers one bit wider than the index. Full and empty are derived from the pointers.
- pop = if_valid & if_ready.
- fetch = ~redirect_valid & (~full | pop).
- On a fetch, the cycle's {pc, imem_instr} pair is pushed and PC <= PC + 4, wrapping modulo 2^32. 32'hFFFF_FFFC is followed by 0.
- When full and not popping, the PC holds and imem_addr is stable. No entry is lost or duplicated.
- Simultaneous push and pop while full is legal: occupancy stays at DEPTH.
- Simultaneous push and pop while at occupancy 1 leaves occupancy at 1.
- Redirect has priority over everything else:
  - The queue is flushed (both pointers reset).
  - PC <= {redirect_pc[31:2], 2'b00}.
  - No push occurs that cycle.
  - A pop asserted in the same cycle still counts as consumed by decode. Flushing makes that irrelevant to the queue.
- Redirects on back-to-back cycles are legal; the last one wins.
- Reset mid-operation clears everything immediately, regardless of clock.

## Timing
- Reset values: PC=RESET_PC, queue empty, occupancy=0, if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC.
- First clock edge after reset release: fetches RESET_PC. if_valid=1 with if_pc=RESET_PC after that edge.
- Fetch-to-decode latency: 1 cycle. The word addressed in cycle N appears at the queue head in cycle N+1 if the queue was empty.
- Steady state with if_ready held high: one instruction per cycle, occupancy stays at 1.
- Redirect at edge N: queue empty and if_valid=0 after N. The target is fetched at edge N+1 and valid after N+1. This is exactly one bubble cycle.
- Outputs if_valid, if_instr, if_pc and occupancy come directly from registers. There is no combinational path from if_ready to any output.

## Configuration
- FETCH_BYPASS_EN defined:
  - When the queue is empty and redirect_valid=0, the outputs present if_valid=1, if_instr=imem_instr and if_pc=PC combinationally. This gives zero-latency fetch.
  - If if_ready=1 in that cycle, the word is consumed directly, nothing is pushed, and PC advances.
  - If if_ready=0, the word is pushed as normal.
  - Reset values are unchanged apart from if_valid, which follows the bypass rule after reset release.
- FETCH_BYPASS_EN undefined:
  - Behaviour is exactly as in Operation/Timing.
  - The outputs are purely registered and the 1-cycle latency applies.

## Test plan
- **Reset and stream.** Memory words 0..3 = 32'h00018880, 32'h04221880, 32'h102520C0, 32'h08062880; RESET_PC=0; if_ready=1 after reset. Required: if_pc sequence 0,4,8,12, one per cycle, with the matching instruction words and occupancy=1 throughout.
- **Backpressure and fill.** if_ready=0 for 8 cycles. Required: occupancy climbs 1..4 and holds at 4; imem_addr freezes at 16. Then raise if_ready: pcs 0,4,8,12,16 drain in order with no gap.
- **Full with simultaneous push/pop.** Queue full, if_ready=1 for one cycle. Required: occupancy stays 4 and the head advances by one pc.
- **Redirect flush.** Queue holding 3 entries, redirect_valid=1 with redirect_pc=32'h0000_0043. Required: after the edge, if_valid=0 and occupancy=0. After the next edge, if_pc=32'h40.
- **PC wrap.** RESET_PC=32'hFFFF_FFF8 with streaming. Required: if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Async reset mid-stream.** Assert rst_n low between clock edges while occupancy=2. Required: if_valid=0, occupancy=0 and imem_addr=RESET_PC immediately, with no clock edge needed.
